// File: rtl/mem_addr_demux_pkg.sv
// rtl/mem_addr_demux_pkg.sv - memory request/response types and target ids for the address demux
package mem_addr_demux_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    mem_type_e               req_type;
    logic [MEM_ADDR_W-1:0]   req_addr;
    logic [MEM_DATA_W-1:0]   req_data;
    logic [MEM_MASK_W-1:0]   req_mask;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0]   resp_data;
  } mem_resp_t;

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_ERR = 2'd2
  } mem_tgt_e;

endpackage

// File: rtl/ot_flop_fifo.sv
// rtl/ot_flop_fifo.sv - flop-based FIFO holding the target id of every outstanding request
module ot_flop_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped even when a pop happens in the same cycle.
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/mem_addr_demux.sv
// rtl/mem_addr_demux.sv - routes master requests to boot ROM / data RAM / error responder by address
// and returns responses in request order through an order FIFO.
module mem_addr_demux
  import mem_addr_demux_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
  parameter logic [MEM_ADDR_W-1:0] S0_MASK  = 32'hFFFF_C000,
  parameter logic [MEM_ADDR_W-1:0] S1_BASE  = 32'h8000_0000,
  parameter logic [MEM_ADDR_W-1:0] S1_MASK  = 32'hFFFF_0000,
  parameter int unsigned           MAX_OT   = 4,
  parameter logic [MEM_DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      mst_req_valid,
  output logic      mst_req_ready,
  input  mem_req_t  mst_req,
  output logic      mst_resp_valid,
  input  logic      mst_resp_ready,
  output mem_resp_t mst_resp,
  output logic      s0_req_valid,
  input  logic      s0_req_ready,
  output mem_req_t  s0_req,
  input  logic      s0_resp_valid,
  output logic      s0_resp_ready,
  input  mem_resp_t s0_resp,
  output logic      s1_req_valid,
  input  logic      s1_req_ready,
  output mem_req_t  s1_req,
  input  logic      s1_resp_valid,
  output logic      s1_resp_ready,
  input  mem_resp_t s1_resp
);

  localparam int unsigned OTW = $clog2(MAX_OT) + 1;

  logic       w_hit0;
  logic       w_hit1;
  mem_tgt_e   w_req_tgt;
  mem_tgt_e   w_head;
  logic [1:0] w_head_raw;
  logic       w_ot_full;
  logic       w_ot_empty;
  logic       w_push;
  logic       w_pop;
  logic [OTW-1:0] r_s0_ot;
  logic [OTW-1:0] r_s1_ot;

  // Slave 0 wins when the two windows overlap.
  assign w_hit0 = ((mst_req.req_addr & S0_MASK) == S0_BASE);
  assign w_hit1 = !w_hit0 && ((mst_req.req_addr & S1_MASK) == S1_BASE);

  always_comb begin
    w_req_tgt = TGT_ERR;
    if (w_hit0)      w_req_tgt = TGT_S0;
    else if (w_hit1) w_req_tgt = TGT_S1;
  end

  assign s0_req       = mst_req;
  assign s1_req       = mst_req;
  assign s0_req_valid = mst_req_valid & w_hit0 & ~w_ot_full & rstn;
  assign s1_req_valid = mst_req_valid & w_hit1 & ~w_ot_full & rstn;

  always_comb begin
    mst_req_ready = 1'b0;
    if (rstn && !w_ot_full) begin
      unique case (w_req_tgt)
        TGT_S0:  mst_req_ready = s0_req_ready;
        TGT_S1:  mst_req_ready = s1_req_ready;
        default: mst_req_ready = 1'b1;
      endcase
    end
  end

  assign w_push = mst_req_valid & mst_req_ready;
  assign w_pop  = mst_resp_valid & mst_resp_ready;

  ot_flop_fifo #(
    .WIDTH ($bits(mem_tgt_e)),
    .DEPTH (MAX_OT)
  ) u_order_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_push_data (w_req_tgt),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_raw),
    .o_full      (w_ot_full),
    .o_empty     (w_ot_empty)
  );

  assign w_head = mem_tgt_e'(w_head_raw);

  // Only the slave owning the oldest request is drained; others stall on their own response port.
  always_comb begin
    mst_resp_valid = 1'b0;
    mst_resp       = '{resp_data: ERR_DATA};
    s0_resp_ready  = 1'b0;
    s1_resp_ready  = 1'b0;
    if (!w_ot_empty) begin
      unique case (w_head)
        TGT_S0: begin
          mst_resp_valid = s0_resp_valid;
          mst_resp       = s0_resp;
          s0_resp_ready  = mst_resp_ready;
        end
        TGT_S1: begin
          mst_resp_valid = s1_resp_valid;
          mst_resp       = s1_resp;
          s1_resp_ready  = mst_resp_ready;
        end
        default: begin
          mst_resp_valid = 1'b1;
          mst_resp       = '{resp_data: ERR_DATA};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s0_ot <= '0;
      r_s1_ot <= '0;
    end else begin
      r_s0_ot <= r_s0_ot + OTW'(w_push && (w_req_tgt == TGT_S0))
                         - OTW'(w_pop && !w_ot_empty && (w_head == TGT_S0));
      r_s1_ot <= r_s1_ot + OTW'(w_push && (w_req_tgt == TGT_S1))
                         - OTW'(w_pop && !w_ot_empty && (w_head == TGT_S1));
    end
  end

  // A slave may hold a response behind another slave's, but never answer with nothing outstanding.
  a_s0_resp_owned: assert property (@(posedge clk) disable iff (!rstn)
    s0_resp_valid |-> (r_s0_ot != '0));
  a_s1_resp_owned: assert property (@(posedge clk) disable iff (!rstn)
    s1_resp_valid |-> (r_s1_ot != '0));

endmodule

// File: tb/tb_mem_addr_demux.sv
// tb/tb_mem_addr_demux.sv - directed bench with an in-order scoreboard model of the address demux
module tb_mem_addr_demux;
  import mem_addr_demux_pkg::*;

  logic      clk = 1'b0;
  logic      rstn = 1'b0;
  logic      mst_req_valid = 1'b0;
  logic      mst_req_ready;
  mem_req_t  mst_req = '0;
  logic      mst_resp_valid;
  logic      mst_resp_ready = 1'b1;
  mem_resp_t mst_resp;
  logic      s0_req_valid, s1_req_valid;
  logic      s0_req_ready = 1'b1, s1_req_ready = 1'b1;
  mem_req_t  s0_req, s1_req;
  logic      s0_resp_valid = 1'b0, s1_resp_valid = 1'b0;
  logic      s0_resp_ready, s1_resp_ready;
  mem_resp_t s0_resp = '0, s1_resp = '0;

  always #5 clk = ~clk;

  mem_addr_demux dut (
    .clk            (clk),
    .rstn           (rstn),
    .mst_req_valid  (mst_req_valid),
    .mst_req_ready  (mst_req_ready),
    .mst_req        (mst_req),
    .mst_resp_valid (mst_resp_valid),
    .mst_resp_ready (mst_resp_ready),
    .mst_resp       (mst_resp),
    .s0_req_valid   (s0_req_valid),
    .s0_req_ready   (s0_req_ready),
    .s0_req         (s0_req),
    .s0_resp_valid  (s0_resp_valid),
    .s0_resp_ready  (s0_resp_ready),
    .s0_resp        (s0_resp),
    .s1_req_valid   (s1_req_valid),
    .s1_req_ready   (s1_req_ready),
    .s1_req         (s1_req),
    .s1_resp_valid  (s1_resp_valid),
    .s1_resp_ready  (s1_resp_ready),
    .s1_resp        (s1_resp)
  );

  typedef struct { int due; logic [31:0] data; } sresp_t;
  typedef struct { int tgt; logic [31:0] data; } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          s0_lat  = 1;
  int          s1_lat  = 1;
  sresp_t      s0_q[$];
  sresp_t      s1_q[$];
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  logic        f_acc = 1'b0, f_pop = 1'b0, f_rst = 1'b1;
  int          f_acc_tgt, f_pop_tgt;
  logic [31:0] f_acc_addr;

  function automatic int tgt_of(logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h8000_0000 && a < 32'h8001_0000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] slave_data(int t, logic [31:0] a);
    return (t == 0) ? (a ^ 32'h1234_5668) : (a ^ 32'hCAFE_0000);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_slaves();
    s0_resp_valid = 1'b0;
    s1_resp_valid = 1'b0;
    if (s0_q.size() > 0) begin
      s0_resp_valid = (s0_q[0].due <= cyc);
      s0_resp.resp_data = s0_q[0].data;
    end
    if (s1_q.size() > 0) begin
      s1_resp_valid = (s1_q[0].due <= cyc);
      s1_resp.resp_data = s1_q[0].data;
    end
  endtask

  // Compare every cycle against the scoreboard, then record the handshakes the next edge will take.
  always @(negedge clk) begin
    int   t, h, sz;
    logic e_rdy, e_rv;
    t  = tgt_of(mst_req.req_addr);
    sz = exp_q.size();
    h  = (sz > 0) ? exp_q[0].tgt : -1;
    e_rdy = rstn && sz < 4 && ((t == 0) ? s0_req_ready : (t == 1) ? s1_req_ready : 1'b1);
    e_rv  = (h == 0) ? s0_resp_valid : (h == 1) ? s1_resp_valid : (h == 2);
    chk("mst_req_ready", {31'b0, mst_req_ready}, {31'b0, e_rdy});
    chk("s0_req_valid", {31'b0, s0_req_valid}, {31'b0, rstn && mst_req_valid && t == 0 && sz < 4});
    chk("s1_req_valid", {31'b0, s1_req_valid}, {31'b0, rstn && mst_req_valid && t == 1 && sz < 4});
    chk("mst_resp_valid", {31'b0, mst_resp_valid}, {31'b0, e_rv});
    chk("s0_resp_ready", {31'b0, s0_resp_ready}, {31'b0, mst_resp_ready && h == 0});
    chk("s1_resp_ready", {31'b0, s1_resp_ready}, {31'b0, mst_resp_ready && h == 1});
    chk("req_passthrough", {31'b0, (s0_req === mst_req) && (s1_req === mst_req)}, 32'd1);
    if (e_rv) chk("resp_data", mst_resp.resp_data, exp_q[0].data);
    f_rst      = !rstn;
    f_acc      = mst_req_valid && e_rdy;
    f_acc_tgt  = t;
    f_acc_addr = mst_req.req_addr;
    f_pop      = e_rv && mst_resp_ready;
    f_pop_tgt  = h;
    if (f_pop) begin
      got_q.push_back(mst_resp.resp_data);
      got_cyc.push_back(cyc);
    end
    if (f_acc) acc_cyc.push_back(cyc);
  end

  always @(posedge clk) begin
    #1;
    if (f_rst) begin
      exp_q.delete();
      s0_q.delete();
      s1_q.delete();
    end else begin
      if (f_pop) begin
        void'(exp_q.pop_front());
        if (f_pop_tgt == 0) void'(s0_q.pop_front());
        if (f_pop_tgt == 1) void'(s1_q.pop_front());
      end
      if (f_acc) begin
        if (f_acc_tgt == 2) begin
          exp_q.push_back('{tgt: 2, data: 32'hDEAD_BEEF});
        end else begin
          exp_q.push_back('{tgt: f_acc_tgt, data: slave_data(f_acc_tgt, f_acc_addr)});
          if (f_acc_tgt == 0) s0_q.push_back('{due: cyc + s0_lat, data: slave_data(0, f_acc_addr)});
          else                s1_q.push_back('{due: cyc + s1_lat, data: slave_data(1, f_acc_addr)});
        end
      end
    end
    cyc++;
    drive_slaves();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(logic [31:0] addr, mem_type_e typ);
    bit done = 0;
    mst_req_valid = 1'b1;
    mst_req = '{req_type: typ, req_addr: addr, req_data: addr + 32'h11, req_mask: 4'hF};
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (mst_req_ready) done = 1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    step();
    mst_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !f_pop) done = 1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rstn = 1'b0;
    mst_req_valid = 1'b1;
    mst_req = '{req_type: MEM_READ, req_addr: 32'h10, req_data: 32'h0, req_mask: 4'hF};
    step();
    @(negedge clk);
    chk("rst_req_ready", {31'b0, mst_req_ready}, 32'd0);
    chk("rst_s0_req_valid", {31'b0, s0_req_valid}, 32'd0);
    chk("rst_resp_valid", {31'b0, mst_resp_valid}, 32'd0);
    step();
    mst_req_valid = 1'b0;
    rstn = 1'b1;
    step();

    // Boot ROM read, one-cycle latency.
    clear_log();
    s0_lat = 1;
    send(32'h0000_0010, MEM_READ);
    wait_idle();
    chk("t1_count", got_q.size(), 32'd1);
    if (got_q.size() == 1) begin
      chk("t1_data", got_q[0], 32'h1234_5678);
      chk("t1_latency", got_cyc[0] - acc_cyc[0], 32'd1);
    end

    // Slow RAM then fast ROM: ROM response waits behind the RAM one.
    clear_log();
    s1_lat = 3;
    send(32'h8000_0000, MEM_READ);
    send(32'h0000_0004, MEM_READ);
    wait_idle();
    chk("t2_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("t2_first", got_q[0], 32'h4AFE_0000);
      chk("t2_second", got_q[1], 32'h1234_566C);
      chk("t2_s1_latency", got_cyc[0] - acc_cyc[0], 32'd3);
      chk("t2_acc_b2b", acc_cyc[1] - acc_cyc[0], 32'd1);
    end
    s1_lat = 1;

    // Unmapped read and write each get one error response.
    clear_log();
    send(32'h4000_0000, MEM_READ);
    wait_idle();
    send(32'h4000_0000, MEM_WRITE);
    wait_idle();
    chk("t3_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("t3_rd_data", got_q[0], 32'hDEAD_BEEF);
      chk("t3_wr_data", got_q[1], 32'hDEAD_BEEF);
      chk("t3_latency", got_cyc[0] - acc_cyc[0], 32'd1);
    end

    // Fill the order FIFO, then a single pop frees a slot only on the following cycle.
    clear_log();
    mst_resp_ready = 1'b0;
    mst_req_valid = 1'b1;
    mst_req = '{req_type: MEM_READ, req_addr: 32'h20, req_data: 32'h0, req_mask: 4'hF};
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mst_req_ready) n_acc++;
      step();
    end
    chk("t4_accepted", n_acc, 32'd4);
    mst_resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_full_pop_ready", {31'b0, mst_req_ready}, 32'd0);
    step();
    mst_resp_ready = 1'b0;
    @(negedge clk);
    chk("t4_after_pop_ready", {31'b0, mst_req_ready}, 32'd1);
    step();
    mst_req_valid = 1'b0;
    mst_resp_ready = 1'b1;
    wait_idle();
    chk("t4_resp_count", got_q.size(), 32'd5);

    // Slave back-pressure: no accept and no push until s0 is ready.
    clear_log();
    s0_req_ready = 1'b0;
    mst_req_valid = 1'b1;
    mst_req = '{req_type: MEM_WRITE, req_addr: 32'h100, req_data: 32'h5, req_mask: 4'h3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_blocked", {31'b0, mst_req_ready}, 32'd0);
      step();
    end
    s0_req_ready = 1'b1;
    @(negedge clk);
    chk("t5_unblocked", {31'b0, mst_req_ready}, 32'd1);
    step();
    mst_req_valid = 1'b0;
    wait_idle();
    chk("t5_count", got_q.size(), 32'd1);
    if (got_q.size() == 1) chk("t5_data", got_q[0], 32'h1234_5768);

    // Reset with two outstanding requests discards them.
    clear_log();
    mst_resp_ready = 1'b0;
    send(32'h0000_0008, MEM_READ);
    send(32'h0000_000C, MEM_READ);
    rstn = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_resp_valid", {31'b0, mst_resp_valid}, 32'd0);
    chk("t6_rst_s0_resp_ready", {31'b0, s0_resp_ready}, 32'd0);
    chk("t6_rst_req_ready", {31'b0, mst_req_ready}, 32'd0);
    step();
    rstn = 1'b1;
    mst_resp_ready = 1'b1;
    clear_log();
    step();
    send(32'h0000_0010, MEM_READ);
    wait_idle();
    chk("t6_count", got_q.size(), 32'd1);
    if (got_q.size() == 1) chk("t6_data", got_q[0], 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
